mram_serial_host: RTL
=====================

MRAM_SERIAL_HOST -- requirements
Module: mram_serial_host

Interface
REQ-001 Parameter ADDR_W, default 20, SHALL set the address width shifted per transaction.
REQ-002 Parameter DATA_W, default 16, SHALL set the data width shifted per transaction (DATA_W <= ADDR_W).
REQ-003 Parameter RD_LAT, default 2, range 1..15, SHALL set the number of idle cycles between the last address bit and the first read-data bit.
REQ-004 Ports SHALL be as follows; the design SHALL use one clock, and reset SHALL be asynchronous and active-high:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  block can accept a request.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  transaction address.
- req_wdata  in  DATA_W  write data.
- read_write_sel  out  1  serial-link direction select.
- addr_ser  out  1  serial address bit, LSB first.
- data_ser  out  1  serial write-data bit, LSB first.
- data_ser_in  in  1  serial read-data return, LSB first.
- done  out  1  one-cycle transaction-complete pulse.
- rd_data  out  DATA_W  captured read data.
- rd_err  out  1  read parity error (see Configuration).

Function
REQ-005 The state machine SHALL use states IDLE, SETUP, SHIFT, WAIT, RECV and DONE.
REQ-006 req_ready SHALL be 1 only in IDLE.
REQ-007 A handshake (req_valid & req_ready at an edge) SHALL latch req_rw, req_addr and req_wdata and move the FSM to SETUP.
REQ-008 req_valid outside IDLE SHALL be ignored and SHALL NOT alter the latched fields.
REQ-009 SETUP SHALL last 1 cycle, with read_write_sel = latched rw and addr_ser = data_ser = 0.
REQ-010 SHIFT SHALL last ADDR_W cycles, using a bit counter k = 0..ADDR_W-1:
- addr_ser = addr[k].
- data_ser = wdata[k] for k < DATA_W on a write; 0 otherwise (always 0 on a read).
- read_write_sel held at the latched rw.
REQ-011 After SHIFT, a write SHALL go to DONE and a read SHALL go to WAIT.
REQ-012 WAIT SHALL last exactly RD_LAT cycles with read_write_sel = 0 and the serial outputs at 0.
REQ-013 RECV SHALL sample data_ser_in on DATA_W consecutive rising edges into rd_data bits 0..DATA_W-1 (LSB first), then go to DONE.
REQ-014 DONE SHALL last 1 cycle:
- done = 1 for that cycle.
- rd_data SHALL remain stable from DONE until the next read enters RECV.
- The FSM SHALL return to IDLE.
REQ-015 In IDLE, read_write_sel, addr_ser, data_ser and done SHALL be 0.
REQ-016 Latency with handshake at edge T:
- Write: done is high in cycle T+ADDR_W+2.
- Read: done is high in cycle T+ADDR_W+RD_LAT+DATA_W+2 (+1 with parity, REQ-022).
REQ-017 A back-to-back request SHALL be accepted at the earliest on the edge after DONE; there SHALL be no overlap between transactions.
REQ-018 The bit counter SHALL be wide enough for ADDR_W and SHALL reset to 0 on every state entry; it SHALL NOT wrap within a state.

Reset
REQ-019 While rst = 1, all outputs SHALL asynchronously take these values: state IDLE, counter 0, req_ready 1, read_write_sel 0, addr_ser 0, data_ser 0, done 0, rd_data 0, rd_err 0.
REQ-020 An rst assertion mid-transaction SHALL abort it without a done pulse; the first edge after release SHALL find the FSM in IDLE and able to accept a request.

Configuration
REQ-021 Macro MRAM_HOST_RD_PARITY_EN SHALL compile read-parity checking in or out.
REQ-022 With MRAM_HOST_RD_PARITY_EN defined:
- RECV SHALL sample DATA_W+1 bits, the last being the even-parity bit over the data.
- rd_err SHALL be updated in DONE: 1 on mismatch, else 0.
- rd_err SHALL hold until the next read's DONE.
REQ-023 Without MRAM_HOST_RD_PARITY_EN, RECV SHALL be DATA_W cycles and rd_err SHALL be constant 0.

Verification
REQ-024 Write, addr=20'h003FF, wdata=16'h03FF -> read_write_sel=1 for 21 cycles; addr_ser and data_ser = 1 for shift bits 0..9 and 0 for bits 10..19; done at T+22.
REQ-025 Read, addr=20'hAAAAA, data_ser_in driving 16'h5555 LSB first starting RD_LAT=2 cycles after shift -> addr_ser alternates 0,1,...; data_ser stays 0; done at T+40 with rd_data=16'h5555.
REQ-026 req_valid held high across two requests -> the second is accepted only on the edge after done; the first request's latched fields are unchanged during SHIFT.
REQ-027 rst pulsed at shift bit 7 of a write -> outputs take reset values immediately, no done pulse, next request completes normally.
REQ-028 With MRAM_HOST_RD_PARITY_EN, read returning 16'h5555 with parity bit 1 -> rd_err=1, done at T+41; with parity bit 0 -> rd_err=0.

Source files
------------

// File: rtl/mram_serial_host.sv
// Serial host for an MRAM link: shifts address/write data out LSB first, waits RD_LAT cycles, then captures read data.
// Optional read-parity checking is compiled in with `define MRAM_HOST_RD_PARITY_EN.
module mram_serial_host #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              read_write_sel,
  output logic              addr_ser,
  output logic              data_ser,
  input  logic              data_ser_in,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam int CNT_MAX = (ADDR_W > 16) ? ADDR_W : 16;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int AIDX_W  = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int DIDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef MRAM_HOST_RD_PARITY_EN
  localparam int RECV_BITS = DATA_W + 1;
`else
  localparam int RECV_BITS = DATA_W;
`endif
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(RECV_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_BITS  = CNT_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, RECV, DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic [AIDX_W-1:0]   w_aidx;
  logic [DIDX_W-1:0]   w_didx;
  logic                w_wbit;
  logic                w_in_data;

  assign w_aidx    = r_cnt[AIDX_W-1:0];
  assign w_didx    = r_cnt[DIDX_W-1:0];
  assign w_in_data = (r_cnt < DATA_BITS);
  assign rd_data   = r_rd_data;

  always_comb begin
    w_wbit = 1'b0;
    if (w_in_data) begin
      w_wbit = r_wdata[w_didx];
    end else begin
      w_wbit = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter restarts on every state change so each phase counts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state == SHIFT || r_state == WAIT || r_state == RECV) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == IDLE && req_valid) begin
      r_rw    <= req_rw;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (r_state == RECV && w_in_data) begin
      r_rd_data[w_didx] <= data_ser_in;
    end
  end

`ifdef MRAM_HOST_RD_PARITY_EN
  logic r_rd_err;

  // The trailing bit is even parity; the flag is ready by the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_err <= 1'b0;
    end else if (r_state == RECV && r_cnt == RECV_LAST) begin
      r_rd_err <= (^r_rd_data) ^ data_ser_in;
    end
  end

  assign rd_err = r_rd_err;
`else
  assign rd_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = req_valid ? SETUP : IDLE;
      SETUP:   w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == SHIFT_LAST) w_state_nxt = r_rw ? DONE : WAIT;
               else w_state_nxt = SHIFT;
      WAIT:    w_state_nxt = (r_cnt == WAIT_LAST) ? RECV : WAIT;
      RECV:    w_state_nxt = (r_cnt == RECV_LAST) ? DONE : RECV;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = 1'b0;
    read_write_sel = 1'b0;
    addr_ser       = 1'b0;
    data_ser       = 1'b0;
    done           = 1'b0;
    case (r_state)
      IDLE:  req_ready = 1'b1;
      SETUP: read_write_sel = r_rw;
      SHIFT: begin
        read_write_sel = r_rw;
        addr_ser       = r_addr[w_aidx];
        data_ser       = r_rw & w_wbit;
      end
      DONE:    done = 1'b1;
      default: req_ready = 1'b0;
    endcase
  end

endmodule
